// File: rtl/ps2_scancode_fifo_pkg.sv
// Shared key-event word layout and PS/2 protocol constants for the keyboard path.
package ps2_scancode_fifo_pkg;

    localparam int KEYWORD_W     = 10;
    localparam int KW_EXT        = 9;
    localparam int KW_REL        = 8;
    localparam int KW_CODE_MSB   = 7;
    localparam int KW_CODE_LSB   = 0;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_VALID = 2'd2
    } head_state_t;

    function automatic logic [KEYWORD_W-1:0] make_keyword(
        input logic       ext,
        input logic       rel,
        input logic [7:0] code
    );
        logic [KEYWORD_W-1:0] w;
        w                           = '0;
        w[KW_EXT]                   = ext;
        w[KW_REL]                   = rel;
        w[KW_CODE_MSB:KW_CODE_LSB]  = code;
        return w;
    endfunction

endpackage

// File: rtl/ps2_scancode_fifo_repeat_filter.sv
// Typematic filter: remembers the last pressed key and drops its auto-repeat make codes.
module ps2_repeat_filter
    import ps2_scancode_fifo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_kb_interrupt,
    input  logic [7:0]           i_scancode,
    input  logic                 i_released,
    input  logic                 i_extended,
    output logic                 o_wr_en,
    output logic [KEYWORD_W-1:0] o_word
);

    logic [8:0] r_held_code;
    logic       r_held_valid;
    logic [8:0] w_key;
    logic       w_match;

    assign w_key   = {i_extended, i_scancode};
    assign w_match = r_held_valid && (r_held_code == w_key);
    assign o_wr_en = i_kb_interrupt && !(!i_released && w_match);
    assign o_word  = make_keyword(i_extended, i_released, i_scancode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_code  <= '0;
            r_held_valid <= 1'b0;
        end else if (i_clear) begin
            r_held_valid <= 1'b0;
        end else if (i_kb_interrupt) begin
            if (!i_released && !w_match) begin
                r_held_code  <= w_key;
                r_held_valid <= 1'b1;
            end else if (i_released && w_match) begin
                r_held_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// Key-event FIFO between the PS/2 receiver and the CPU scancode register, with registered head output.
module ps2_scancode_fifo
    import ps2_scancode_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kb_interrupt,
    input  logic [7:0]            scancode,
    input  logic                  released,
    input  logic                  extended,
    input  logic                  rd,
    input  logic                  clear,
    output logic [KEYWORD_W-1:0]  dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic                   w_wr_req;
    logic [KEYWORD_W-1:0]   w_word;

    generate
        if (FILTER_REPEAT) begin : g_filter
            ps2_repeat_filter u_filter (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_clear        (clear),
                .i_kb_interrupt (kb_interrupt),
                .i_scancode     (scancode),
                .i_released     (released),
                .i_extended     (extended),
                .o_wr_en        (w_wr_req),
                .o_word         (w_word)
            );
        end else begin : g_bypass
            assign w_wr_req = kb_interrupt;
            assign w_word   = make_keyword(extended, released, scancode);
        end
    endgenerate

    logic [KEYWORD_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wptr;
    logic [DEPTH_LOG2-1:0]  r_rptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic                   r_overflow;
    logic [KEYWORD_W-1:0]   r_dout;
    head_state_t            r_state;
    head_state_t            w_state_next;
    logic [DEPTH_LOG2:0]    w_count_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == FULL_COUNT);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign dout     = r_dout;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign w_pop  = rd && !empty && !clear;
    assign w_push = w_wr_req && (!full || w_pop) && !clear;
    assign w_drop = w_wr_req && full && !w_pop && !clear;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (DEPTH_LOG2+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - (DEPTH_LOG2+1)'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear || (w_count_next == '0)) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_push) w_state_next = ST_LOAD;
                ST_LOAD:  w_state_next = w_pop ? ST_LOAD : ST_VALID;
                ST_VALID: if (w_pop) w_state_next = ST_LOAD;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
            r_count <= w_count_next;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // A pop during LOAD fetches a stale head; the FSM stays in LOAD so it is refetched next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ST_IDLE) begin
                r_dout <= '0;
            end else if (r_state == ST_LOAD) begin
                r_dout <= r_mem[r_rptr];
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Directed scoreboard bench for ps2_scancode_fifo (DEPTH_LOG2=4, FILTER_REPEAT=1).
module tb_ps2_scancode_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kb_interrupt;
    logic [7:0]  scancode;
    logic        released;
    logic        extended;
    logic        rd;
    logic        clear;
    logic [9:0]  dout;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [9:0]  sb[$];
    logic [8:0]  m_held;
    logic        m_held_v;
    logic        m_ovf;

    always #5 clk = ~clk;

    ps2_scancode_fifo #(.DEPTH_LOG2(4), .FILTER_REPEAT(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kb_interrupt (kb_interrupt),
        .scancode     (scancode),
        .released     (released),
        .extended     (extended),
        .rd           (rd),
        .clear        (clear),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model of the filter decision plus FIFO capacity; updates the scoreboard.
    task automatic model_event(input logic e, input logic r, input logic [7:0] c);
        logic [8:0] k;
        logic       hit;
        k   = {e, c};
        hit = m_held_v && (m_held == k);
        if (!r && hit) begin
            return;
        end
        if (!r) begin
            m_held   = k;
            m_held_v = 1'b1;
        end else if (hit) begin
            m_held_v = 1'b0;
        end
        if (sb.size() < 16) sb.push_back({e, r, c});
        else                m_ovf = 1'b1;
    endtask

    task automatic send(input logic e, input logic r, input logic [7:0] c);
        model_event(e, r, c);
        extended     = e;
        released     = r;
        scancode     = c;
        kb_interrupt = 1'b1;
        tick();
        kb_interrupt = 1'b0;
        chk("send_count", count, sb.size());
        chk("send_ovf", overflow, m_ovf);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] exp;
        tick();
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h000;
        chk(tag, dout, exp);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("pop_count", count, sb.size());
    endtask

    initial begin
        rst_n = 1'b0; kb_interrupt = 1'b0; scancode = '0; released = 1'b0;
        extended = 1'b0; rd = 1'b0; clear = 1'b0;
        m_held = '0; m_held_v = 1'b0; m_ovf = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First event: count next cycle, dout one cycle after that.
        send(1'b0, 1'b0, 8'h1C);
        chk("first_empty", empty, 0);
        chk("first_dout_latency", dout, 0);
        tick();
        chk("first_dout", dout, 10'h01C);

        // Typematic repeats dropped, break passes.
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b1, 8'h1C);
        chk("repeat_count", count, 2);
        pop_check("repeat_pop0");
        pop_check("repeat_pop1");
        chk("repeat_empty", empty, 1);
        chk("repeat_dout0", dout, 0);

        // Extended make; plain break of same code does not release the held key.
        send(1'b1, 1'b0, 8'h75);
        tick();
        chk("ext_dout", dout, 10'h275);
        send(1'b0, 1'b1, 8'h75);
        send(1'b1, 1'b0, 8'h75);
        chk("ext_count", count, 2);
        pop_check("ext_pop0");
        pop_check("ext_pop1");
        send(1'b1, 1'b1, 8'h75);
        pop_check("ext_break");

        // Overfill with 17 distinct makes.
        for (int i = 0; i < 17; i++) begin
            send(1'b0, 1'b0, 8'h10 + 8'(i));
            if (i == 14) chk("fill_notfull", full, 0);
            if (i == 15) chk("fill_full", full, 1);
        end
        chk("ovf_set", overflow, 1);
        for (int i = 0; i < 16; i++) pop_check("ovf_pop");
        chk("ovf_sticky", overflow, 1);
        chk("ovf_empty", empty, 1);

        // Clear wins over a same-cycle write, which is lost silently.
        scancode = 8'h99; released = 1'b0; extended = 1'b0;
        kb_interrupt = 1'b1; clear = 1'b1;
        tick();
        kb_interrupt = 1'b0; clear = 1'b0;
        m_ovf = 1'b0; m_held_v = 1'b0;
        chk("clear_ovf", overflow, 0);
        chk("clear_count", count, 0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 8'h20 + 8'(i));
        chk("sim_full", full, 1);
        tick();
        chk("sim_head", dout, sb.pop_front());
        model_event(1'b0, 1'b0, 8'h40);
        scancode = 8'h40; released = 1'b0; extended = 1'b0;
        kb_interrupt = 1'b1; rd = 1'b1;
        tick();
        kb_interrupt = 1'b0; rd = 1'b0;
        chk("sim_count", count, 16);
        chk("sim_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) pop_check("sim_pop");
        chk("sim_last_empty", empty, 1);

        // Read while empty is ignored.
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("under_count", count, 0);
        chk("under_empty", empty, 1);
        chk("under_dout", dout, 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 8'h50 + 8'(i));
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete(); m_held_v = 1'b0; m_ovf = 1'b0;
        chk("mrst_count", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_dout", dout, 0);
        chk("mrst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(1'b0, 1'b0, 8'h54);
        chk("mrst_accept", count, 1);
        pop_check("mrst_pop");
        chk("mrst_final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
